// File: rtl/data_store_buffer.sv
// Posted-write buffer between the CPU memory stage and the data cache: stores queue in a FIFO and
// retire in the background; loads wait for the FIFO to drain so memory ordering stays strict.
module data_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_cpu_addr,
  input  logic [31:0]      i_cpu_write_data,
  input  logic             i_cpu_memwrite,
  input  logic             i_cpu_memread,
  input  logic [3:0]       i_cpu_sign_mask,
  output logic [31:0]      o_cpu_read_data,
  output logic             o_cpu_stall,
  output logic [31:0]      o_c_addr,
  output logic [31:0]      o_c_write_data,
  output logic             o_c_memwrite,
  output logic             o_c_memread,
  output logic [3:0]       o_c_sign_mask,
  input  logic [31:0]      i_c_read_data,
  input  logic             i_c_stall,
  output logic [PTR_W:0]   o_fifo_count
);

  typedef enum logic [1:0] {IDLE, ST_WAIT, LD_WAIT, RESP} state_t;

  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  state_t           r_state;
  state_t           w_nextState;

  logic [31:0]      r_addrMem [DEPTH];
  logic [31:0]      r_dataMem [DEPTH];
  logic [3:0]       r_maskMem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;

  logic             r_started;
  logic [31:0]      r_cAddr;
  logic [31:0]      r_cWriteData;
  logic [3:0]       r_cSignMask;
  logic [31:0]      r_cpuReadData;

  logic             w_isLoad;
  logic             w_isStore;
  logic             w_full;
  logic             w_empty;
  logic             w_done;
  logic             w_issueSt;
  logic             w_issueLd;
  logic             w_pop;
  logic             w_push;
  logic             w_capture;

  // A load wins when both requests are raised; nothing is requested while reset is held.
  assign w_isLoad  = rst_n & i_cpu_memread;
  assign w_isStore = rst_n & i_cpu_memwrite & ~i_cpu_memread;
  assign w_full    = (r_count == COUNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_done    = r_started & ~i_c_stall;

  always_comb begin
    w_nextState = r_state;
    w_issueSt   = 1'b0;
    w_issueLd   = 1'b0;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !i_c_stall) begin
          w_issueSt   = 1'b1;
          w_nextState = ST_WAIT;
        end else if (w_empty && w_isLoad && !i_c_stall) begin
          w_issueLd   = 1'b1;
          w_nextState = LD_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_done) begin
          w_pop       = 1'b1;
          w_nextState = IDLE;
        end
      end
      LD_WAIT: begin
        if (w_done) begin
          w_capture   = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A retire frees a slot in the same cycle, so a waiting store slips in without an extra stall.
  assign w_push      = w_isStore & (~w_full | w_pop);
  assign o_cpu_stall = (w_isStore & w_full & ~w_pop) | (w_isLoad & (r_state != RESP));

  assign o_c_memwrite   = w_issueSt;
  assign o_c_memread    = w_issueLd;
  assign o_c_addr       = w_issueSt ? r_addrMem[r_rdPtr] : (w_issueLd ? i_cpu_addr : r_cAddr);
  assign o_c_write_data = w_issueSt ? r_dataMem[r_rdPtr] : r_cWriteData;
  assign o_c_sign_mask  = w_issueSt ? r_maskMem[r_rdPtr] : (w_issueLd ? i_cpu_sign_mask : r_cSignMask);
  assign o_cpu_read_data = r_cpuReadData;
  assign o_fifo_count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_started <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_WAIT || r_state == LD_WAIT) begin
        if (!r_started && i_c_stall) begin
          r_started <= 1'b1;
        end else if (w_done) begin
          r_started <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addrMem[r_wrPtr] <= i_cpu_addr;
      r_dataMem[r_wrPtr] <= i_cpu_write_data;
      r_maskMem[r_wrPtr] <= i_cpu_sign_mask;
    end
  end

  // The cache-side fields are latched at the request so they stay put until the transaction ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cAddr       <= '0;
      r_cWriteData  <= '0;
      r_cSignMask   <= '0;
      r_cpuReadData <= '0;
    end else begin
      if (w_issueSt) begin
        r_cAddr      <= r_addrMem[r_rdPtr];
        r_cWriteData <= r_dataMem[r_rdPtr];
        r_cSignMask  <= r_maskMem[r_rdPtr];
      end else if (w_issueLd) begin
        r_cAddr     <= i_cpu_addr;
        r_cSignMask <= i_cpu_sign_mask;
      end
      if (w_capture) begin
        r_cpuReadData <= i_c_read_data;
      end
    end
  end

endmodule

// File: tb/tb_data_store_buffer.sv
// Testbench for data_store_buffer: a CPU-side driver, a simple cache model and a
// queue-based scoreboard that checks cache traffic, load results and FIFO occupancy.
module tb_data_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wrEntry_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
  } rdReq_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      cpuAddr;
  logic [31:0]      cpuWriteData;
  logic             cpuMemwrite;
  logic             cpuMemread;
  logic [3:0]       cpuSignMask;
  logic [31:0]      cpuReadData;
  logic             cpuStall;
  logic [31:0]      cAddr;
  logic [31:0]      cWriteData;
  logic             cMemwrite;
  logic             cMemread;
  logic [3:0]       cSignMask;
  logic [31:0]      cReadData;
  logic             cStall;
  logic [PTR_W:0]   fifoCount;

  wrEntry_t         expWrQ[$];
  rdReq_t           expRdReqQ[$];
  logic [31:0]      expLdQ[$];
  logic [31:0]      refMem[logic [31:0]];
  logic [31:0]      cacheMem[logic [31:0]];

  int               testCount = 0;
  int               failCount = 0;
  int               forceLat = 0;
  int               cycleCnt = 0;
  int               lastRdReqCycle = -1;
  int               expCount = 0;

  logic             pendWrite;
  logic [31:0]      pendAddr;
  logic [31:0]      pendData;
  int               busyLeft;
  logic             doneWrite;
  logic             prevMemwrite;

  data_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cpu_addr       (cpuAddr),
    .i_cpu_write_data (cpuWriteData),
    .i_cpu_memwrite   (cpuMemwrite),
    .i_cpu_memread    (cpuMemread),
    .i_cpu_sign_mask  (cpuSignMask),
    .o_cpu_read_data  (cpuReadData),
    .o_cpu_stall      (cpuStall),
    .o_c_addr         (cAddr),
    .o_c_write_data   (cWriteData),
    .o_c_memwrite     (cMemwrite),
    .o_c_memread      (cMemread),
    .o_c_sign_mask    (cSignMask),
    .i_c_read_data    (cReadData),
    .i_c_stall        (cStall),
    .o_fifo_count     (fifoCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  function automatic logic [31:0] defaultWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : defaultWord(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    testCount++;
    failCount++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Cache model: stall rises the cycle after a request and falls after a random or forced latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cStall    <= 1'b0;
      cReadData <= '0;
      busyLeft  <= 0;
      doneWrite <= 1'b0;
      pendWrite <= 1'b0;
      pendAddr  <= '0;
      pendData  <= '0;
    end else begin
      doneWrite <= 1'b0;
      if (cStall) begin
        if (busyLeft <= 1) begin
          cStall <= 1'b0;
          if (pendWrite) begin
            cacheMem[pendAddr] = pendData;
            doneWrite <= 1'b1;
          end else begin
            cReadData <= cacheMem.exists(pendAddr) ? cacheMem[pendAddr] : defaultWord(pendAddr);
          end
        end else begin
          busyLeft <= busyLeft - 1;
        end
      end else if (cMemwrite || cMemread) begin
        cStall    <= 1'b1;
        pendWrite <= cMemwrite;
        pendAddr  <= cAddr;
        pendData  <= cWriteData;
        busyLeft  <= (forceLat != 0) ? forceLat : int'($urandom_range(1, 3));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      expCount = 0;
    end else begin
      checkOutput("fifo_count", 32'(fifoCount), 32'(expCount));
      if (cpuMemwrite && !cpuMemread) begin
        if (expCount < DEPTH)  checkOutput("store_no_stall", 32'(cpuStall), 32'd0);
        else if (!doneWrite)   checkOutput("store_full_stall", 32'(cpuStall), 32'd1);
        else                   checkOutput("store_retire_accept", 32'(cpuStall), 32'd0);
      end
      if (cpuMemwrite && !cpuMemread && !cpuStall) expCount++;
      if (doneWrite) expCount--;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a cache request or a load result.
  always @(negedge clk) begin
    wrEntry_t we;
    rdReq_t   rr;
    if (rst_n) begin
      if (cMemwrite || cMemread) checkOutput("req_while_busy", 32'(cStall), 32'd0);
      if (cMemwrite) begin
        checkOutput("c_memwrite_pulse", 32'(prevMemwrite), 32'd0);
        if (expWrQ.size() == 0) begin
          reportFail("unexpected_store", $sformatf("got c_addr 0x%08h, required no store", cAddr));
        end else begin
          we = expWrQ.pop_front();
          checkOutput("c_addr_wr", cAddr, we.addr);
          checkOutput("c_write_data", cWriteData, we.data);
          checkOutput("c_sign_mask_wr", 32'(cSignMask), 32'(we.mask));
        end
      end
      if (cMemread) begin
        lastRdReqCycle = cycleCnt;
        checkOutput("load_after_drain", 32'(fifoCount), 32'd0);
        if (expRdReqQ.size() == 0) begin
          reportFail("unexpected_load", $sformatf("got c_addr 0x%08h, required no load", cAddr));
        end else begin
          rr = expRdReqQ.pop_front();
          checkOutput("c_addr_rd", cAddr, rr.addr);
          checkOutput("c_sign_mask_rd", 32'(cSignMask), 32'(rr.mask));
        end
      end
      if (cpuMemread && !cpuStall) begin
        if (expLdQ.size() == 0) begin
          reportFail("unexpected_load_resp", $sformatf("got 0x%08h, required no response", cpuReadData));
        end else begin
          checkOutput("cpu_read_data", cpuReadData, expLdQ.pop_front());
        end
      end
      prevMemwrite = cMemwrite;
    end else begin
      prevMemwrite = 1'b0;
    end
  end

  // One CPU access (0 store, 1 load, 2 load+store); returns how many cycles it stalled.
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] mask, output int waited);
    rdReq_t   rr;
    wrEntry_t we;
    cpuAddr      = addr;
    cpuWriteData = data;
    cpuSignMask  = mask;
    cpuMemwrite  = (kind != 1);
    cpuMemread   = (kind != 0);
    if (kind != 0) begin
      rr.addr = addr;
      rr.mask = mask;
      expRdReqQ.push_back(rr);
      expLdQ.push_back(refRead(addr));
    end
    waited = 0;
    forever begin
      @(negedge clk);
      if (!cpuStall) break;
      waited++;
      if (waited > 300) break;
    end
    if (waited > 300) begin
      reportFail("access_timeout", $sformatf("still stalled after %0d cycles, required completion", waited));
    end else if (kind == 0) begin
      we.addr = addr;
      we.data = data;
      we.mask = mask;
      expWrQ.push_back(we);
      refMem[addr] = data;
    end
    @(posedge clk);
    #1;
    cpuMemwrite = 1'b0;
    cpuMemread  = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((fifoCount != 0 || cStall) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) reportFail("drain_timeout", $sformatf("fifo_count %0d after %0d cycles, required 0", fifoCount, n));
    @(posedge clk);
    #1;
  endtask

  task automatic clearScoreboard();
    expWrQ.delete();
    expRdReqQ.delete();
    expLdQ.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int wArr[5];
    int startCycle;
    logic [3:0] maskTab[5];
    maskTab[0] = 4'b0111; maskTab[1] = 4'b0011; maskTab[2] = 4'b0001;
    maskTab[3] = 4'b1001; maskTab[4] = 4'b1011;

    rst_n = 1'b0;
    cpuAddr = '0; cpuWriteData = '0; cpuMemwrite = 1'b0; cpuMemread = 1'b0; cpuSignMask = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_fifo_count", 32'(fifoCount), 32'd0);
    checkOutput("reset_c_memwrite", 32'(cMemwrite), 32'd0);
    checkOutput("reset_cpu_read_data", cpuReadData, 32'd0);
    rst_n = 1'b1;

    // Reset with stores still queued.
    forceLat = 20;
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h9000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'b0111, w);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cpuMemread = 1'b1;
    #1;
    checkOutput("t1_fifo_count", 32'(fifoCount), 32'd0);
    checkOutput("t1_cpu_stall", 32'(cpuStall), 32'd0);
    clearScoreboard();
    @(posedge clk);
    #1;
    checkOutput("t1_c_memwrite", 32'(cMemwrite), 32'd0);
    checkOutput("t1_c_memread", 32'(cMemread), 32'd0);
    checkOutput("t1_c_addr", cAddr, 32'd0);
    cpuMemread = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    forceLat = 0;

    // Single store goes to the cache in the following cycle.
    applyStimulus(0, 32'h4000, 32'hDEADBEEF, 4'b0111, w);
    checkOutput("t2_no_stall", 32'(w), 32'd0);
    @(negedge clk);
    checkOutput("t2_c_memwrite", 32'(cMemwrite), 32'd1);
    checkOutput("t2_c_addr", cAddr, 32'h4000);
    checkOutput("t2_c_write_data", cWriteData, 32'hDEADBEEF);
    waitDrain();

    // Five back-to-back stores against a slow cache.
    forceLat = 6;
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h4100 + 32'(i * 4), $urandom, 4'b0111, wArr[i]);
    checkOutput("t3_count_full", 32'(fifoCount), 32'd4);
    applyStimulus(0, 32'h4110, $urandom, 4'b0111, wArr[4]);
    for (int i = 0; i < 4; i++) checkOutput("t3_accept_no_stall", 32'(wArr[i]), 32'd0);
    checkOutput("t3_fifth_stalled", 32'(wArr[4] > 0), 32'd1);
    waitDrain();
    forceLat = 0;

    // Load behind a queued store to the same address.
    applyStimulus(0, 32'h4004, 32'h12345678, 4'b0111, w);
    applyStimulus(1, 32'h4004, 32'h0, 4'b0111, w);
    checkOutput("t4_load_stalled", 32'(w > 0), 32'd1);
    checkOutput("t4_read_data", cpuReadData, 32'h12345678);
    waitDrain();

    // Signed byte load with an empty FIFO.
    cacheMem[32'h4008] = 32'h000000F0;
    refMem[32'h4008]   = 32'h000000F0;
    startCycle = cycleCnt;
    applyStimulus(1, 32'h4008, 32'h0, 4'b1001, w);
    checkOutput("t5_issue_cycle", 32'(lastRdReqCycle), 32'(startCycle));
    checkOutput("t5_read_data", cpuReadData, 32'h000000F0);

    // Reset while a load is waiting on the cache.
    forceLat = 10;
    begin
      rdReq_t rr;
      rr.addr = 32'h4010;
      rr.mask = 4'b0111;
      expRdReqQ.push_back(rr);
    end
    cpuAddr = 32'h4010; cpuSignMask = 4'b0111; cpuMemread = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_cpu_stall", 32'(cpuStall), 32'd0);
    checkOutput("t6_read_data_reset", cpuReadData, 32'd0);
    clearScoreboard();
    cpuMemread = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    forceLat = 0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("t6_no_stale_update", cpuReadData, 32'd0);

    // Randomised mix of stores, loads and combined requests.
    for (int i = 0; i < 120; i++) begin
      int k;
      logic [31:0] a;
      k = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 15) == 0) ? 32'h2000 : 32'h4000 + 32'($urandom_range(0, 7) * 4);
      applyStimulus((k <= 5) ? 0 : ((k <= 8) ? 1 : 2), a, $urandom, maskTab[$urandom_range(0, 4)], w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    waitDrain();
    checkOutput("end_stores_outstanding", 32'(expWrQ.size()), 32'd0);
    checkOutput("end_loads_outstanding", 32'(expLdQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
